axi_single_beat_initiator: RTL and testbench

Single-outstanding AXI4 initiator converting a simple valid/ready register-access request port into single-beat AXI4 read or write transactions. It is the driving end for the PLIC and timer AXI slave ports of the peripherals subsystem: debug or bring-up logic in the block design issues claim/complete and mtime/mtimecmp accesses through it. One transaction is in flight at a time.

---
 rtl/axi_single_beat_initiator_pkg.sv | 26 ++
 rtl/axi_single_beat_initiator_verilog.sv | 64 ++++++
 rtl/axi_single_beat_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_axi_single_beat_initiator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_single_beat_initiator_pkg.sv
// Shared types and AXI constants for the single-beat AXI4 initiator.
package axi_single_beat_initiator_pkg;

    // Transaction sequencer states; one access in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_READ   = 3'd3,
        ST_WAIT_R = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    // AxSIZE encoding for a full-width beat (32-bit -> 2, 64-bit -> 3).
    function automatic logic [2:0] beat_size(input int data_width);
        return (data_width == 64) ? 3'd3 : 3'd2;
    endfunction

endpackage

// File: rtl/axi_single_beat_initiator_verilog.sv
// Plain-Verilog-port wrapper so the initiator can be dropped into a block design.
module axi_single_beat_initiator_verilog #(
    parameter AXI_ADDR_WIDTH = 64,
    parameter AXI_DATA_WIDTH = 64,
    parameter AXI_ID_WIDTH   = 6,
    parameter AXI_USER_WIDTH = 1,
    parameter AXI_ID         = 0
) (
    input  wire                        aclk, aresetn,
    input  wire                        req_valid, req_we, rsp_ready,
    output wire                        req_ready, rsp_valid, rsp_err,
    input  wire [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  wire [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  wire [AXI_DATA_WIDTH/8-1:0] req_strb,
    output wire [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output wire [AXI_ID_WIDTH-1:0]     m_axi_awid, m_axi_arid,
    output wire [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr, m_axi_araddr,
    output wire [7:0]                  m_axi_awlen, m_axi_arlen,
    output wire [2:0]                  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot,
    output wire [1:0]                  m_axi_awburst, m_axi_arburst,
    output wire                        m_axi_awlock, m_axi_arlock,
    output wire [3:0]                  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos,
    output wire [3:0]                  m_axi_awregion, m_axi_arregion,
    output wire [AXI_USER_WIDTH-1:0]   m_axi_awuser, m_axi_aruser, m_axi_wuser,
    output wire                        m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_wlast,
    input  wire                        m_axi_awready, m_axi_arready, m_axi_wready,
    output wire [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output wire [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    input  wire [AXI_ID_WIDTH-1:0]     m_axi_bid, m_axi_rid,
    input  wire [1:0]                  m_axi_bresp, m_axi_rresp,
    input  wire [AXI_USER_WIDTH-1:0]   m_axi_buser, m_axi_ruser,
    input  wire                        m_axi_bvalid, m_axi_rvalid, m_axi_rlast,
    output wire                        m_axi_bready, m_axi_rready,
    input  wire [AXI_DATA_WIDTH-1:0]   m_axi_rdata
);

    axi_single_beat_initiator #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .AXI_ID_WIDTH(AXI_ID_WIDTH), .AXI_USER_WIDTH(AXI_USER_WIDTH), .AXI_ID(AXI_ID)
    ) u_core (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

endmodule

// File: rtl/axi_single_beat_initiator.sv
// Converts valid/ready register-access requests into single-beat AXI4
// reads or writes, one outstanding transaction, all outputs registered.
module axi_single_beat_initiator
    import axi_single_beat_initiator_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 1,
    parameter int AXI_ID         = 0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_strb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic [3:0]                  m_axi_awregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_awuser,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_wuser,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_buser,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arqos,
    output logic [3:0]                  m_axi_arregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_aruser,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_ruser,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam logic [2:0] BEAT_SIZE = beat_size(AXI_DATA_WIDTH);

    state_e                        state_q;
    logic                          req_ready_q;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   strb_q;
    logic                          awvalid_q, wvalid_q, arvalid_q;
    logic                          bready_q, rready_q;
    logic                          rsp_valid_q, rsp_err_q;
    logic [AXI_DATA_WIDTH-1:0]     rsp_rdata_q;

    // With a single transaction outstanding, IDs, user bits and rlast carry no information.
    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_buser, m_axi_rid, m_axi_rlast, m_axi_ruser};

    // Sequencer: request capture, AXI channel handshakes, response hold.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        strb_q      <= req_strb;
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    // AW and W retire independently; leave once both have completed.
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (m_axi_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_err_q   <= (m_axi_bresp != RESP_OKAY);
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_READ: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (m_axi_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_err_q   <= (m_axi_rresp != RESP_OKAY);
                        rsp_rdata_q <= m_axi_rdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;

    assign m_axi_awid     = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = BEAT_SIZE;
    assign m_axi_awburst  = BURST_INCR;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'd0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awuser   = '0;
    assign m_axi_awvalid  = awvalid_q;

    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = strb_q;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_wuser    = '0;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_bready   = bready_q;

    assign m_axi_arid     = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = BEAT_SIZE;
    assign m_axi_arburst  = BURST_INCR;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_aruser   = '0;
    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_rready   = rready_q;

endmodule

// File: tb/tb_axi_single_beat_initiator.sv
// Directed bench for axi_single_beat_initiator with a behavioural AXI slave
// and a response scoreboard.
module tb_axi_single_beat_initiator;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_strb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic [5:0]  awid, arid, bid, rid;
    logic [63:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion;
    logic [0:0]  awuser, aruser, wuser, buser, ruser;
    logic        awvalid, awready, wvalid, wready, wlast;
    logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

    always #5 aclk = ~aclk;

    axi_single_beat_initiator dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
        .m_axi_awuser(awuser), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wuser(wuser),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_buser(buser), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
        .m_axi_aruser(aruser), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_ruser(ruser), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Slave configuration and observations.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [63:0] cfg_rdata = '0;
    bit          b_hold = 1'b0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0;
    logic [63:0] awaddr_cap, wdata_cap, araddr_cap;
    logic [7:0]  wstrb_cap, awlen_cap;
    logic [2:0]  awsize_cap, arsize_cap;
    logic [1:0]  awburst_cap;
    logic        wlast_cap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural AXI slave, evaluated on the falling edge: readies for the
    // coming rising edge are decided here and handshakes are recorded.
    initial begin
        bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        bit aw_done = 0, w_done = 0, ar_pend = 0;
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0; bid = 0; rid = 0; buser = 0; ruser = 0; rlast = 1;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_done = 0; w_done = 0; ar_pend = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            end else begin
                if (aw_hs) begin aw_done = 1; aw_hs_cnt++; end
                if (w_hs)  begin w_done = 1;  w_hs_cnt++;  end
                if (b_hs)  begin bvalid = 0; aw_done = 0; w_done = 0; b_hs_cnt++; end
                if (ar_hs) begin ar_pend = 1; ar_hs_cnt++; end
                if (r_hs)  rvalid = 0;
                if (awvalid) begin aw_hi++; awready = (aw_cnt == aw_delay); aw_cnt++; end
                else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin w_hi++; wready = (w_cnt == w_delay); w_cnt++; end
                else begin wready = 0; w_cnt = 0; end
                if (arvalid) begin ar_hi++; arready = (ar_cnt == ar_delay); ar_cnt++; end
                else begin arready = 0; ar_cnt = 0; end
                if (aw_done && w_done && !bvalid && !b_hold) begin bvalid = 1; bresp = cfg_bresp; end
                if (ar_pend && !rvalid) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; ar_pend = 0; end
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                b_hs  = bvalid && bready;
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                if (aw_hs) begin
                    awaddr_cap = awaddr; awlen_cap = awlen; awsize_cap = awsize; awburst_cap = awburst;
                end
                if (w_hs) begin wdata_cap = wdata; wstrb_cap = wstrb; wlast_cap = wlast; end
                if (ar_hs) begin araddr_cap = araddr; arsize_cap = arsize; end
            end
        end
    end

    // Present a request from a falling edge; returns on the falling edge of cycle 1.
    task automatic send_req(input logic we, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic [63:0] exp_rdata, input logic exp_err);
        int n = 0;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = data; req_strb = strb;
        while (!req_ready && n < 50) begin @(negedge aclk); n++; end
        check("req_accepted", req_ready, 1);
        @(negedge aclk);
        req_valid = 0;
        $display("req  we=%0d addr=0x%0h wdata=0x%0h strb=0x%0h", we, addr, data, strb);
    endtask

    // Wait for rsp_valid, compare against the scoreboard, let it handshake.
    task automatic wait_rsp(input string tag, output int cyc);
        int   n = 1;
        exp_t e;
        while (!rsp_valid && n < 60) begin @(negedge aclk); n++; end
        cyc = n;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, rsp_err, e.err);
        end
        $display("rsp  %s cycle=%0d rdata=0x%0h err=%0d", tag, cyc, rsp_rdata, rsp_err);
        @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, n;
        int   aw0, w0, b0, ar0, awh0, wh0, arh0;
        exp_t e;
        aresetn = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        rsp_ready = 1;
        repeat (3) @(negedge aclk);
        check("rst_req_ready", req_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        aresetn = 1;
        @(negedge aclk);
        check("post_rst_req_ready", req_ready, 1);

        // Zero-wait write.
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        send_req(1, 64'h0000_0000_0200_4000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0);
        wait_rsp("wr0", cyc);
        check("wr0_cycle", cyc, 3);
        check("wr0_awaddr", awaddr_cap, 64'h0200_4000);
        check("wr0_wdata", wdata_cap, 64'h1122_3344_5566_7788);
        check("wr0_wstrb", wstrb_cap, 8'hFF);
        check("wr0_wlast", wlast_cap, 1);
        check("wr0_awsize", awsize_cap, 3);
        check("wr0_awlen", awlen_cap, 0);
        check("wr0_awburst", awburst_cap, 2'b01);
        check("wr0_aw_hs", aw_hs_cnt - aw0, 1);
        check("wr0_w_hs", w_hs_cnt - w0, 1);
        check("wr0_b_hs", b_hs_cnt - b0, 1);

        // Read with arready delayed 5 cycles.
        ar_delay = 5; cfg_rdata = 64'h7; cfg_rresp = 2'b00; arh0 = ar_hi;
        send_req(0, 64'h0000_0000_0C20_0004, 64'h0, 8'h0, 64'h7, 1'b0);
        wait_rsp("rd0", cyc);
        check("rd0_arvalid_cycles", ar_hi - arh0, 6);
        check("rd0_araddr", araddr_cap, 64'h0C20_0004);
        check("rd0_arsize", arsize_cap, 3);
        check("rd0_cycle", cyc, 8);
        ar_delay = 0;

        // Write with AW accepted at once and W three cycles later.
        aw_delay = 0; w_delay = 3; awh0 = aw_hi; wh0 = w_hi; b0 = b_hs_cnt;
        send_req(1, 64'h0000_0000_0200_BFF8, 64'hCAFE_0000_1234_5678, 8'h0F, 64'h0, 1'b0);
        wait_rsp("wr1", cyc);
        check("wr1_awvalid_cycles", aw_hi - awh0, 1);
        check("wr1_wvalid_cycles", w_hi - wh0, 4);
        check("wr1_b_hs", b_hs_cnt - b0, 1);
        check("wr1_wdata", wdata_cap, 64'hCAFE_0000_1234_5678);
        check("wr1_cycle", cyc, 6);
        w_delay = 0;

        // Read returning SLVERR, then a DECERR write that must clear rdata.
        cfg_rresp = 2'b10; cfg_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        send_req(0, 64'h0000_0000_0C20_0008, 64'h0, 8'h0, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
        wait_rsp("rd_slverr", cyc);
        cfg_rresp = 2'b00; cfg_bresp = 2'b11;
        send_req(1, 64'h0000_0000_0200_4004, 64'h55, 8'h01, 64'h0, 1'b1);
        wait_rsp("wr_decerr", cyc);
        cfg_bresp = 2'b00;

        // Response back-pressure with a second request waiting.
        rsp_ready = 0;
        send_req(1, 64'h0000_0000_0200_4008, 64'hA5A5_A5A5_5A5A_5A5A, 8'hF0, 64'h0, 1'b0);
        n = 1;
        while (!rsp_valid && n < 60) begin @(negedge aclk); n++; end
        check("stall_rsp_seen", rsp_valid, 1);
        cfg_rdata = 64'h1234; cfg_rresp = 2'b00;
        sb_q.push_back('{rdata: 64'h1234, err: 1'b0});
        req_valid = 1; req_we = 0; req_addr = 64'h0200_BFFC; req_wdata = 0; req_strb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("stall_req_ready", req_ready, 0);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_rdata", rsp_rdata, 0);
            check("stall_arvalid", arvalid, 0);
        end
        e = sb_q.pop_front();
        check("stall_rsp_exp_rdata", rsp_rdata, e.rdata);
        check("stall_rsp_exp_err", rsp_err, e.err);
        $display("rsp  stalled write released rdata=0x%0h err=%0d", rsp_rdata, rsp_err);
        rsp_ready = 1;
        @(negedge aclk);
        check("after_stall_req_ready", req_ready, 1);
        check("after_stall_rsp_valid", rsp_valid, 0);
        @(negedge aclk);
        req_valid = 0;
        check("second_req_arvalid", arvalid, 1);
        check("second_req_ready_low", req_ready, 0);
        $display("req  we=0 addr=0x200bffc (accepted after stall)");
        wait_rsp("rd_after_stall", cyc);
        check("rd_after_stall_cycle", cyc, 3);

        // Reset while waiting for B.
        b_hold = 1;
        send_req(1, 64'h0000_0000_0200_4010, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 64'h0, 1'b0);
        n = 0;
        while (!bready && n < 20) begin @(negedge aclk); n++; end
        check("waitb_bready", bready, 1);
        #2 aresetn = 0;
        #1;
        check("midrst_bready", bready, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_awvalid", awvalid, 0);
        check("sb_depth_at_reset", sb_q.size(), 1);
        sb_q.delete();
        $display("rst  asserted in WAIT_B, pending write discarded");
        @(negedge aclk);
        b_hold = 0;
        aresetn = 1;
        @(negedge aclk);
        check("rerst_req_ready", req_ready, 1);
        b0 = b_hs_cnt;
        send_req(1, 64'h0000_0000_0200_4018, 64'h0102_0304_0506_0708, 8'hFF, 64'h0, 1'b0);
        wait_rsp("wr_after_rst", cyc);
        check("wr_after_rst_cycle", cyc, 3);
        check("wr_after_rst_b_hs", b_hs_cnt - b0, 1);
        check("wr_after_rst_awaddr", awaddr_cap, 64'h0200_4018);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
